core_output_arbiter: RTL and testbench

CORE_OUTPUT_ARBITER -- requirements
Module: core_output_arbiter

---
 rtl/core_arb_pkg.sv | 17 +
 rtl/core_output_arbiter_rr_pick.sv | 30 +++
 rtl/core_output_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_core_output_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_arb_pkg.sv
// Shared definitions for the core output arbiter: FSM state encoding and default bus widths.
package core_arb_pkg;

    localparam int unsigned BUS_W_DEF  = 24;
    localparam int unsigned CTRL_W_DEF = 25;

    localparam logic [1:0] ARB_IDLE    = 2'd0;
    localparam logic [1:0] ARB_GRANT   = 2'd1;
    localparam logic [1:0] ARB_RELEASE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = ARB_IDLE,
        ST_GRANT   = ARB_GRANT,
        ST_RELEASE = ARB_RELEASE
    } arb_state_e;

endpackage

// File: rtl/core_output_arbiter_rr_pick.sv
// Combinational round-robin search: first requester strictly after last_grant, wrapping at NUM_CORES-1.
module rr_pick #(
    parameter int unsigned NUM_CORES = 4
) (
    input  logic [NUM_CORES-1:0]         req,
    input  logic [$clog2(NUM_CORES)-1:0] last_grant,
    output logic [NUM_CORES-1:0]         pick_c,
    output logic                         valid_c
);

    localparam int unsigned IDX_W = $clog2(NUM_CORES);

    int unsigned idx_v;
    logic        found;

    always_comb begin
        pick_c = '0;
        found  = 1'b0;
        idx_v  = 0;
        for (int unsigned k = 1; k <= NUM_CORES; k++) begin
            idx_v = (32'(last_grant) + k) % NUM_CORES;
            if (!found && req[IDX_W'(idx_v)]) begin
                pick_c[IDX_W'(idx_v)] = 1'b1;
                found                 = 1'b1;
            end
        end
        valid_c = found;
    end

endmodule

// File: rtl/core_output_arbiter.sv
// Round-robin arbiter muxing one of NUM_CORES core output channels onto a shared registered bus.
// Optional build macro ARB_TIMEOUT_EN adds a GRANT-cycle watchdog that forces release.
module core_output_arbiter
    import core_arb_pkg::*;
#(
    parameter int unsigned NUM_CORES   = 4,
    parameter int unsigned BUS_W       = BUS_W_DEF,
    parameter int unsigned CTRL_W      = CTRL_W_DEF,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_CORES-1:0]             req,
    input  logic [NUM_CORES*BUS_W-1:0]       c_bus_out,
    input  logic [NUM_CORES*CTRL_W-1:0]      c_ctrlsig_out,
    input  logic [NUM_CORES-1:0]             c_endp,
    input  logic [NUM_CORES-1:0]             c_Zout,
    output logic [BUS_W-1:0]                 bus_out,
    output logic [CTRL_W-1:0]                ctrlsig_out,
    output logic                             endp,
    output logic                             Zout,
    output logic [NUM_CORES-1:0]             grant,
    output logic [$clog2(NUM_CORES+1)-1:0]   select_core,
    output logic                             busy,
    output logic                             timeout
);

    localparam int unsigned IDX_W = $clog2(NUM_CORES);
    localparam int unsigned SEL_W = $clog2(NUM_CORES + 1);

    if (NUM_CORES < 2 || NUM_CORES > 16 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("core_output_arbiter: illegal parameterisation");
    end

    logic [1:0]           state_q, state_d;
    logic [NUM_CORES-1:0] grant_q, grant_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [IDX_W-1:0]     gidx_q, gidx_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [BUS_W-1:0]     bus_q, bus_d;
    logic [CTRL_W-1:0]    ctrl_q, ctrl_d;
    logic                 endp_q, endp_d;
    logic                 zout_q, zout_d;
    logic                 busy_q, busy_d;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`endif

    logic [NUM_CORES-1:0] pick_c;
    logic                 pick_valid_c;
    logic [IDX_W-1:0]     pick_idx_c;

    logic [BUS_W-1:0]  bus_arr  [NUM_CORES];
    logic [CTRL_W-1:0] ctrl_arr [NUM_CORES];

    // Unpack the flat per-core buses into indexable arrays
    for (genvar g = 0; g < NUM_CORES; g++) begin : g_slice
        assign bus_arr[g]  = c_bus_out[g*BUS_W +: BUS_W];
        assign ctrl_arr[g] = c_ctrlsig_out[g*CTRL_W +: CTRL_W];
    end

    rr_pick #(
        .NUM_CORES (NUM_CORES)
    ) u_rr_pick (
        .req        (req),
        .last_grant (last_q),
        .pick_c     (pick_c),
        .valid_c    (pick_valid_c)
    );

    always_comb begin
        pick_idx_c = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (pick_c[i]) begin
                pick_idx_c = IDX_W'(i);
            end
        end
    end

    // Next-state and registered-output logic; data outputs default to zero outside GRANT
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        bus_d   = '0;
        ctrl_d  = '0;
        endp_d  = 1'b0;
        zout_d  = 1'b0;
        busy_d  = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid_c) begin
                    state_d = ARB_GRANT;
                    grant_d = pick_c;
                    sel_d   = SEL_W'(pick_idx_c) + SEL_W'(1);
                    gidx_d  = pick_idx_c;
                    busy_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ARB_GRANT: begin
                bus_d  = bus_arr[gidx_q];
                ctrl_d = ctrl_arr[gidx_q];
                endp_d = c_endp[gidx_q];
                zout_d = c_Zout[gidx_q];
                busy_d = 1'b1;
                if (c_endp[gidx_q]) begin
                    state_d = ARB_RELEASE;
                    grant_d = '0;
                    sel_d   = '0;
                    busy_d  = 1'b0;
`ifdef ARB_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d   = ARB_RELEASE;
                    grant_d   = '0;
                    sel_d     = '0;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            ARB_RELEASE: begin
                last_d  = gidx_q;
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
                sel_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            gidx_q  <= '0;
            last_q  <= IDX_W'(NUM_CORES - 1);
            bus_q   <= '0;
            ctrl_q  <= '0;
            endp_q  <= 1'b0;
            zout_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            bus_q   <= bus_d;
            ctrl_q  <= ctrl_d;
            endp_q  <= endp_d;
            zout_q  <= zout_d;
            busy_q  <= busy_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Watchdog counter and one-cycle timeout pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign bus_out     = bus_q;
    assign ctrlsig_out = ctrl_q;
    assign endp        = endp_q;
    assign Zout        = zout_q;
    assign grant       = grant_q;
    assign select_core = sel_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_core_output_arbiter.sv
// Bench for core_output_arbiter: directed vector table, hand-written reset/timeout sequences, randomized run vs. ownership model.
module tb_core_output_arbiter;

    localparam int NC     = 4;
    localparam int BW     = 24;
    localparam int CW     = 25;
    localparam int TO_CYC = 8;
    localparam int SW     = $clog2(NC + 1);
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic [NC-1:0]    req;
    logic [NC*BW-1:0] c_bus_out;
    logic [NC*CW-1:0] c_ctrlsig_out;
    logic [NC-1:0]    c_endp;
    logic [NC-1:0]    c_Zout;
    logic [BW-1:0]    bus_out;
    logic [CW-1:0]    ctrlsig_out;
    logic             endp;
    logic             Zout;
    logic [NC-1:0]    grant;
    logic [SW-1:0]    select_core;
    logic             busy;
    logic             timeout;

    core_output_arbiter #(
        .NUM_CORES   (NC),
        .BUS_W       (BW),
        .CTRL_W      (CW),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .c_bus_out     (c_bus_out),
        .c_ctrlsig_out (c_ctrlsig_out),
        .c_endp        (c_endp),
        .c_Zout        (c_Zout),
        .bus_out       (bus_out),
        .ctrlsig_out   (ctrlsig_out),
        .endp          (endp),
        .Zout          (Zout),
        .grant         (grant),
        .select_core   (select_core),
        .busy          (busy),
        .timeout       (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [NC-1:0] req;
        logic [NC-1:0] endp_in;
        logic [NC-1:0] grant;
        int            sel;
        logic          busy;
        int            core;
        logic          endp_out;
    } vec_t;

    vec_t tbl [16];

    // Ownership model state for the randomized phase
    int            m_owner;
    bit            m_rel;
    int            m_last;
    int            m_gcyc;
    logic [NC-1:0] e_grant;
    logic [SW-1:0] e_sel;
    logic          e_busy;
    logic [BW-1:0] e_bus;
    logic [CW-1:0] e_ctrl;
    logic          e_endp;
    logic          e_z;
    logic          e_to;

    function automatic logic [BW-1:0] pat_bus(input int i);
        return BW'(32'h00A5_0000 + 32'(i) * 32'h0000_1111);
    endfunction

    function automatic logic [CW-1:0] pat_ctrl(input int i);
        return CW'(32'h0155_0000 + 32'(i) * 32'h0000_0077);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [NC-1:0] eg, input logic [SW-1:0] es,
                         input logic eb, input logic [BW-1:0] ebus, input logic [CW-1:0] ectrl,
                         input logic ee, input logic ez, input logic et);
        n_total++;
        if ({grant, select_core, busy, bus_out, ctrlsig_out, endp, Zout, timeout} !==
            {eg, es, eb, ebus, ectrl, ee, ez, et}) begin
            $display("FAIL %s: got grant=%b sel=%0d busy=%b bus=%h ctrl=%h endp=%b zout=%b timeout=%b, expected grant=%b sel=%0d busy=%b bus=%h ctrl=%h endp=%b zout=%b timeout=%b",
                     name, grant, select_core, busy, bus_out, ctrlsig_out, endp, Zout, timeout,
                     eg, es, eb, ebus, ectrl, ee, ez, et);
        end else begin
            n_pass++;
        end
    endtask

    // Expected outputs when the data path carries the fixed pattern of a given core (-1 = zeros)
    task automatic check_core(input string name, input logic [NC-1:0] eg, input int es, input logic eb,
                              input int core, input logic ee, input logic et);
        logic [BW-1:0] xb;
        logic [CW-1:0] xc;
        logic          xz;
        xb = '0;
        xc = '0;
        xz = 1'b0;
        if (core >= 0) begin
            xb = pat_bus(core);
            xc = pat_ctrl(core);
            xz = (core % 2) == 1;
        end
        check(name, eg, SW'(es), eb, xb, xc, ee, xz, et);
    endtask

    task automatic model_step();
        e_grant = '0;
        e_sel   = '0;
        e_busy  = 1'b0;
        e_bus   = '0;
        e_ctrl  = '0;
        e_endp  = 1'b0;
        e_z     = 1'b0;
        e_to    = 1'b0;
        if (m_rel) begin
            m_last  = m_owner;
            m_owner = -1;
            m_rel   = 1'b0;
        end else if (m_owner >= 0) begin
            e_bus  = c_bus_out[m_owner*BW +: BW];
            e_ctrl = c_ctrlsig_out[m_owner*CW +: CW];
            e_endp = c_endp[m_owner];
            e_z    = c_Zout[m_owner];
            m_gcyc++;
            if (c_endp[m_owner] || (TO_EN && m_gcyc >= TO_CYC)) begin
                m_rel = 1'b1;
                e_to  = TO_EN && !c_endp[m_owner];
            end else begin
                e_grant = NC'(1) << m_owner;
                e_sel   = SW'(m_owner + 1);
                e_busy  = 1'b1;
            end
        end else if (req != '0) begin
            for (int k = 1; k <= NC; k++) begin
                int c;
                c = (m_last + k) % NC;
                if (req[c]) begin
                    m_owner = c;
                    break;
                end
            end
            m_gcyc  = 0;
            e_grant = NC'(1) << m_owner;
            e_sel   = SW'(m_owner + 1);
            e_busy  = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //                req      endp_in  grant    sel busy core endp
        tbl[0]  = '{4'b0110, 4'b0000, 4'b0010, 2, 1'b1, -1, 1'b0};
        tbl[1]  = '{4'b0110, 4'b0000, 4'b0010, 2, 1'b1,  1, 1'b0};
        tbl[2]  = '{4'b0111, 4'b0010, 4'b0000, 0, 1'b0,  1, 1'b1};
        tbl[3]  = '{4'b0111, 4'b0000, 4'b0000, 0, 1'b0, -1, 1'b0};
        tbl[4]  = '{4'b0111, 4'b0000, 4'b0100, 3, 1'b1, -1, 1'b0};
        tbl[5]  = '{4'b0111, 4'b0100, 4'b0000, 0, 1'b0,  2, 1'b1};
        tbl[6]  = '{4'b1000, 4'b0000, 4'b0000, 0, 1'b0, -1, 1'b0};
        tbl[7]  = '{4'b1000, 4'b0000, 4'b1000, 4, 1'b1, -1, 1'b0};
        tbl[8]  = '{4'b0000, 4'b0001, 4'b1000, 4, 1'b1,  3, 1'b0};
        tbl[9]  = '{4'b0000, 4'b0000, 4'b1000, 4, 1'b1,  3, 1'b0};
        tbl[10] = '{4'b1001, 4'b1000, 4'b0000, 0, 1'b0,  3, 1'b1};
        tbl[11] = '{4'b1001, 4'b0000, 4'b0000, 0, 1'b0, -1, 1'b0};
        tbl[12] = '{4'b1001, 4'b0000, 4'b0001, 1, 1'b1, -1, 1'b0};
        tbl[13] = '{4'b0000, 4'b0001, 4'b0000, 0, 1'b0,  0, 1'b1};
        tbl[14] = '{4'b0000, 4'b0000, 4'b0000, 0, 1'b0, -1, 1'b0};
        tbl[15] = '{4'b0000, 4'b0000, 4'b0000, 0, 1'b0, -1, 1'b0};

        rst_n  = 1'b0;
        req    = '0;
        c_endp = '0;
        c_Zout = 4'b1010;
        for (int i = 0; i < NC; i++) begin
            c_bus_out[i*BW +: BW]     = pat_bus(i);
            c_ctrlsig_out[i*CW +: CW] = pat_ctrl(i);
        end
        repeat (3) step();
        check_core("reset", '0, 0, 1'b0, -1, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Directed table: first grant, endp release, round-robin skip, req drop ignored, wrap-around
        for (int i = 0; i < 16; i++) begin
            req    = tbl[i].req;
            c_endp = tbl[i].endp_in;
            step();
            check_core($sformatf("vec%0d", i), tbl[i].grant, tbl[i].sel, tbl[i].busy,
                       tbl[i].core, tbl[i].endp_out, 1'b0);
        end

        // Asynchronous reset in the middle of a grant
        req    = 4'b0010;
        c_endp = '0;
        step();
        check_core("rst_pre_grant", 4'b0010, 2, 1'b1, -1, 1'b0, 1'b0);
        step();
        check_core("rst_in_grant", 4'b0010, 2, 1'b1, 1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_core("rst_async_zero", '0, 0, 1'b0, -1, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        req   = 4'b1000;
        step();
        check_core("rst_then_core3", 4'b1000, 4, 1'b1, -1, 1'b0, 1'b0);
        req = '0;
        step();
        check_core("rst_core3_data", 4'b1000, 4, 1'b1, 3, 1'b0, 1'b0);
        c_endp = 4'b1000;
        step();
        check_core("rst_core3_endp", '0, 0, 1'b0, 3, 1'b1, 1'b0);
        c_endp = '0;
        step();
        check_core("rst_core3_idle", '0, 0, 1'b0, -1, 1'b0, 1'b0);

        // Core 0 holds the bus without ever raising endp
        req = 4'b0001;
        step();
        check_core("hold_grant", 4'b0001, 1, 1'b1, -1, 1'b0, 1'b0);
        req = '0;
        for (int i = 1; i < TO_CYC; i++) begin
            step();
            check_core($sformatf("hold%0d", i), 4'b0001, 1, 1'b1, 0, 1'b0, 1'b0);
        end
        step();
`ifdef ARB_TIMEOUT_EN
        check_core("timeout_release", '0, 0, 1'b0, 0, 1'b0, 1'b1);
        step();
        check_core("timeout_cleared", '0, 0, 1'b0, -1, 1'b0, 1'b0);
`else
        check_core("no_timeout_hold", 4'b0001, 1, 1'b1, 0, 1'b0, 1'b0);
        repeat (20) step();
        check_core("no_timeout_long", 4'b0001, 1, 1'b1, 0, 1'b0, 1'b0);
        c_endp = 4'b0001;
        step();
        check_core("hold_endp", '0, 0, 1'b0, 0, 1'b1, 1'b0);
        c_endp = '0;
        step();
        check_core("hold_idle", '0, 0, 1'b0, -1, 1'b0, 1'b0);
`endif

        // Randomized run against the ownership model
        rst_n = 1'b0;
        step();
        rst_n   = 1'b1;
        m_owner = -1;
        m_rel   = 1'b0;
        m_last  = NC - 1;
        m_gcyc  = 0;
        for (int n = 0; n < 600; n++) begin
            req = NC'($urandom);
            for (int i = 0; i < NC; i++) begin
                c_bus_out[i*BW +: BW]     = BW'($urandom);
                c_ctrlsig_out[i*CW +: CW] = CW'($urandom);
                c_endp[i]                 = ($urandom_range(0, 5) == 0);
                c_Zout[i]                 = 1'($urandom);
            end
            model_step();
            step();
            check($sformatf("rand%0d", n), e_grant, e_sel, e_busy, e_bus, e_ctrl, e_endp, e_z, e_to);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
